// File: rtl/remote_cmd_sequencer.sv
// remote_cmd_sequencer: queues Knight commands and plays them one at a time
// into a RemoteComm-style transmitter. For each command it waits for the
// response, checks it against ACK, applies a timeout, and reports done/err.
// Optional feature macro: CMDQ_RETRY_EN (resend a failed command up to
// MAX_RETRY times before it is abandoned).
`timescale 1ns/1ps

module remote_cmd_sequencer #(
  parameter int unsigned        CMD_W     = 16,
  parameter int unsigned        RESP_W    = 8,
  parameter int unsigned        DEPTH     = 8,
  parameter logic [RESP_W-1:0]  ACK       = 8'hA5,
  parameter int unsigned        TO_W      = 24,
  parameter logic [TO_W-1:0]    TIMEOUT   = 24'd5_000_000,
  parameter int unsigned        MAX_RETRY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [CMD_W-1:0]        push_cmd,
  input  logic                    en,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    send_cmd,
  output logic [CMD_W-1:0]        cmd,
  input  logic                    cmd_sent,
  input  logic                    resp_rdy,
  input  logic [RESP_W-1:0]       resp,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [7:0]              err_cnt,
  output logic [RESP_W-1:0]       last_resp
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Expiry is detected one cycle early so the registered err lands exactly
  // TIMEOUT cycles after send_cmd.
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_SENT = 2'd2,
    S_WAIT_RESP = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [CMD_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_nxt;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_cnt_nxt;

  logic               pop;
  logic               push_ok;
  logic               waiting;
  logic               resp_hit;
  logic               resp_ok;
  logic               expired;
  logic               fail;
  logic               retry_ok;

  logic               send_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic               busy_nxt;
  logic [CMD_W-1:0]   cmd_nxt;
  logic [RESP_W-1:0]  last_resp_nxt;
  logic [7:0]         err_cnt_nxt;

  assign pop      = (state == S_IDLE) && en && !empty;
  assign push_ok  = push && !full;
  assign waiting  = (state == S_WAIT_SENT) || (state == S_WAIT_RESP);
  assign resp_hit = (state == S_WAIT_RESP) && resp_rdy;
  assign resp_ok  = resp_hit && (resp == ACK);
  assign expired  = waiting && (to_cnt == TO_LAST);
  // A response on the expiry cycle takes precedence over the timeout.
  assign fail     = (resp_hit && (resp != ACK)) || (!resp_hit && expired);

`ifdef CMDQ_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RTY_W-1:0] retry_cnt;

  assign retry_ok = (32'(retry_cnt) < MAX_RETRY);

  // Resend counter for the command in flight; cleared on every pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (pop) begin
      retry_cnt <= '0;
    end else if (fail && retry_ok) begin
      retry_cnt <= retry_cnt + RTY_W'(1);
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pop) state_nxt = S_SEND;
      end
      S_SEND: begin
        state_nxt = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (fail)          state_nxt = retry_ok ? S_SEND : S_IDLE;
        else if (cmd_sent) state_nxt = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (resp_ok)   state_nxt = S_IDLE;
        else if (fail) state_nxt = retry_ok ? S_SEND : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    send_nxt      = (state_nxt == S_SEND);
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = resp_ok;
    err_nxt       = fail && !retry_ok;
    cmd_nxt       = cmd;
    last_resp_nxt = last_resp;
    err_cnt_nxt   = err_cnt;
    to_cnt_nxt    = to_cnt;

    if (pop)                          cmd_nxt       = mem[rd_ptr];
    if (resp_hit)                     last_resp_nxt = resp;
    if (err_nxt && (err_cnt != 8'hFF)) err_cnt_nxt  = err_cnt + 8'd1;

    // Counts cycles elapsed since send_cmd
    if (state == S_SEND)  to_cnt_nxt = TO_W'(1);
    else if (waiting)     to_cnt_nxt = to_cnt + TO_W'(1);
  end

  // Queue occupancy next value
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Queue storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_cmd;
  end

  // Queue pointers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Registered outputs and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_cmd  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd       <= '0;
      last_resp <= '0;
      err_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      send_cmd  <= send_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      cmd       <= cmd_nxt;
      last_resp <= last_resp_nxt;
      err_cnt   <= err_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// Directed bench for remote_cmd_sequencer with a transmitter model and a
// scoreboard of expected command order and outcomes.
`timescale 1ns/1ps

module tb_remote_cmd_sequencer;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned RESP_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TMO    = 100;
  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;

  typedef enum int {M_ACK, M_SILENT, M_EXACT, M_SENT_ONLY} mode_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               push = 1'b0;
  logic [CMD_W-1:0]   push_cmd = '0;
  logic               en = 1'b0;
  logic               full, empty;
  logic [$clog2(DEPTH):0] count;
  logic               send_cmd;
  logic [CMD_W-1:0]   cmd;
  logic               cmd_sent = 1'b0;
  logic               resp_rdy = 1'b0;
  logic [RESP_W-1:0]  resp = '0;
  logic               busy, done, err;
  logic [7:0]         err_cnt;
  logic [RESP_W-1:0]  last_resp;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mode_t mode = M_ACK;
  int    resp_idx = 0;
  int    bad_at = -1;

  logic [CMD_W-1:0] exp_cmd[$];
  int               exp_out[$];
  int               exp_errs = 0;

  int          n_send = 0, n_done = 0, n_err = 0;
  int          send_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [7:0]  err_resp = '0;

  remote_cmd_sequencer #(
    .CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .ACK(8'hA5),
    .TO_W(24), .TIMEOUT(24'(TMO)), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd), .en(en),
    .full(full), .empty(empty), .count(count), .send_cmd(send_cmd),
    .cmd(cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .last_resp(last_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every send/done/err pulse
  initial forever begin
    @(negedge clk);
    if (send_cmd) begin
      n_send++;
      send_cyc = cyc;
      if (exp_cmd.size() == 0) chk("send_unexpected", 32'(exp_cmd.size()), 32'd1);
      else                     chk("send_cmd_order", 32'(cmd), 32'(exp_cmd.pop_front()));
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (exp_out.size() == 0) chk("done_unexpected", 32'(exp_out.size()), 32'd1);
      else                     chk("outcome_done", 32'(OUT_DONE), 32'(exp_out.pop_front()));
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
      err_resp = last_resp;
      if (exp_out.size() == 0) chk("err_unexpected", 32'(exp_out.size()), 32'd1);
      else                     chk("outcome_err", 32'(OUT_ERR), 32'(exp_out.pop_front()));
    end
  end

  // Transmitter model
  initial forever begin
    @(negedge clk);
    if (send_cmd && mode != M_SILENT) begin
      @(negedge clk); cmd_sent = 1'b1;
      @(negedge clk); cmd_sent = 1'b0;
      if (mode == M_EXACT) begin
        repeat (TMO - 3) @(negedge clk);
        resp = 8'hA5; resp_rdy = 1'b1;
        @(negedge clk); resp_rdy = 1'b0;
      end else if (mode == M_ACK) begin
        @(negedge clk);
        resp = (resp_idx == bad_at) ? 8'h5A : 8'hA5;
        resp_idx++;
        resp_rdy = 1'b1;
        @(negedge clk); resp_rdy = 1'b0;
      end
    end
  end

  task automatic do_push(input logic [CMD_W-1:0] c, input bit expect_send);
    push = 1'b1;
    push_cmd = c;
    if (expect_send) exp_cmd.push_back(c);
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((busy || !empty || exp_cmd.size() != 0 || exp_out.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < max), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_empty"},     32'(empty),     32'd1);
    chk({tag, "_full"},      32'(full),      32'd0);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_send_cmd"},  32'(send_cmd),  32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    chk({tag, "_last_resp"}, 32'(last_resp), 32'd0);
    chk({tag, "_cmd"},       32'(cmd),       32'd0);
  endtask

  initial begin
    int base_send, base_err, base_done;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Three commands, all ACKed
    en = 1'b1;
    base_send = n_send; base_done = n_done;
    do_push(16'h2002, 1'b1);
    do_push(16'h4001, 1'b1);
    do_push(16'h6000, 1'b1);
    repeat (3) exp_out.push_back(OUT_DONE);
    drain("drain_basic", 200);
    chk("basic_sends",   32'(n_send - base_send), 32'd3);
    chk("basic_dones",   32'(n_done - base_done), 32'd3);
    chk("basic_err_cnt", 32'(err_cnt), 32'd0);
    chk("basic_empty",   32'(empty),   32'd1);

    // Fill with run disabled; ninth push is dropped
    en = 1'b0;
    base_send = n_send;
    for (int i = 0; i < 9; i++) do_push(16'h1000 + 16'(i), i < 8);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_busy",  32'(busy),  32'd0);
    repeat (8) exp_out.push_back(OUT_DONE);
    en = 1'b1;
    @(negedge clk);
    chk("pop_count_dec", 32'(count),    32'd7);
    chk("pop_send_next", 32'(send_cmd), 32'd1);
    chk("pop_full_clr",  32'(full),     32'd0);
    drain("drain_fill", 600);
    chk("fill_sends", 32'(n_send - base_send), 32'd8);
    chk("fill_empty", 32'(empty), 32'd1);

    // Bad response to the first of two commands
    base_send = n_send; base_err = n_err;
    bad_at = resp_idx;
    do_push(16'h3001, 1'b1);
`ifdef CMDQ_RETRY_EN
    exp_cmd.push_back(16'h3001);
    exp_out.push_back(OUT_DONE);
`else
    exp_out.push_back(OUT_ERR);
    exp_errs++;
`endif
    do_push(16'h3002, 1'b1);
    exp_out.push_back(OUT_DONE);
    drain("drain_bad", 300);
    chk("bad_err_cnt",   32'(err_cnt),   32'(exp_errs));
    chk("bad_last_resp", 32'(last_resp), 32'h0A5);
`ifdef CMDQ_RETRY_EN
    chk("bad_sends", 32'(n_send - base_send), 32'd3);
    chk("bad_errs",  32'(n_err - base_err),   32'd0);
`else
    chk("bad_sends",    32'(n_send - base_send), 32'd2);
    chk("bad_errs",     32'(n_err - base_err),   32'd1);
    chk("bad_err_resp", 32'(err_resp),           32'h05A);
`endif

    // No response at all: timeout
    mode = M_SILENT;
    base_send = n_send; base_err = n_err;
    do_push(16'h4444, 1'b1);
`ifdef CMDQ_RETRY_EN
    exp_cmd.push_back(16'h4444);
    exp_cmd.push_back(16'h4444);
`endif
    exp_out.push_back(OUT_ERR);
    exp_errs++;
    drain("drain_timeout", 800);
    chk("timeout_latency", 32'(err_cyc - send_cyc), 32'(TMO));
`ifdef CMDQ_RETRY_EN
    chk("timeout_sends", 32'(n_send - base_send), 32'd3);
`else
    chk("timeout_sends", 32'(n_send - base_send), 32'd1);
`endif
    chk("timeout_errs",    32'(n_err - base_err), 32'd1);
    chk("timeout_err_cnt", 32'(err_cnt), 32'(exp_errs));

    // Response on the expiry cycle wins over the timeout
    mode = M_EXACT;
    base_err = n_err; base_done = n_done;
    do_push(16'h5005, 1'b1);
    exp_out.push_back(OUT_DONE);
    drain("drain_race", 300);
    chk("race_done_latency", 32'(done_cyc - send_cyc), 32'(TMO));
    chk("race_dones",   32'(n_done - base_done), 32'd1);
    chk("race_errs",    32'(n_err - base_err),   32'd0);
    chk("race_err_cnt", 32'(err_cnt), 32'(exp_errs));

    // Reset while waiting for a response with three commands queued
    mode = M_SENT_ONLY;
    do_push(16'h6001, 1'b1);
    do_push(16'h6002, 1'b0);
    do_push(16'h6003, 1'b0);
    do_push(16'h6004, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_busy",  32'(busy),  32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    base_send = n_send;
    repeat (20) @(negedge clk);
    chk("post_rst_sends", 32'(n_send - base_send), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_busy",  32'(busy),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/remote_cmd_sequencer.md
# remote_cmd_sequencer

Parametrised command sequencer that buffers a queue of Knight commands and plays them, one at a time, into a RemoteComm-style transmitter (`send_cmd`/`cmd`/`cmd_sent`/`resp_rdy`/`resp`). For each command it waits for a response, checks it against the acknowledge code, enforces a timeout, and reports completion and errors. It sits between a host or stimulus source and RemoteComm, replacing hand-sequenced send-and-wait logic with a reusable, self-checking engine.

## Interface
- CMD_W, 16, command width
- RESP_W, 8, response width
- DEPTH, 8, queue depth in entries; power of 2, ≥2
- ACK, 8'hA5, response value counted as success (RESP_W bits)
- TO_W, 24, timeout counter width
- TIMEOUT, 24'd5_000_000, cycles allowed from `send_cmd` to `resp_rdy`
- MAX_RETRY, 2, resends per command (used only with retry compiled in)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- push  in  1  enqueue `push_cmd`; ignored when `full`
- push_cmd  in  CMD_W  command to enqueue
- en  in  1  run enable; low → halt in IDLE after the current command
- full / empty  out  1  queue status
- count  out  $clog2(DEPTH)+1  entries queued (excludes the command in flight)
- send_cmd  out  1  one-cycle pulse to the transmitter
- cmd  out  CMD_W  command in flight; held stable from `send_cmd` until return to IDLE
- cmd_sent  in  1  transmitter finished sending
- resp_rdy  in  1  response valid, one-cycle pulse
- resp  in  RESP_W  response byte
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse: command completed with ACK
- err  out  1  one-cycle pulse: command abandoned (bad response or timeout)
- err_cnt  out  8  saturating error count (stops at 8'hFF)
- last_resp  out  RESP_W  most recently received response

## Operation
- Circular FIFO with read/write pointers plus count.
- States:
  - IDLE: if `en && !empty`, pop the head into the `cmd` register → SEND.
  - SEND: assert `send_cmd` for one cycle, clear the timeout counter → WAIT_SENT.
  - WAIT_SENT: wait for `cmd_sent` → WAIT_RESP.
  - WAIT_RESP: wait for `resp_rdy`; latch `resp` into `last_resp`. If `resp==ACK`, pulse `done` → IDLE. Otherwise it is a failure.
- The timeout counter runs in WAIT_SENT and WAIT_RESP. When it reaches TIMEOUT without `resp_rdy`, the command fails.
- On failure: pulse `err`, increment `err_cnt` (saturating) → IDLE.
- `resp_rdy` arriving in WAIT_SENT is ignored.
- `en` is sampled only in IDLE; deasserting it never aborts an in-flight command.

## Timing
- Reset values: all outputs 0, `empty`=1, `count`=0, state IDLE, pointers 0. Asynchronous reset mid-command discards the queue and the in-flight command.
- Pop-to-send latency: `send_cmd` rises the cycle after the IDLE pop.
- `count` decrements the cycle after the pop.
- `push` with `full`=1 is dropped and leaves the queue unchanged. Push and pop in the same cycle leave `count` unchanged. A push into an empty queue is poppable on the next cycle; there is no same-cycle bypass.
- Pointers wrap modulo DEPTH.
- `done` or `err` pulses the cycle after the response is received or the timeout expires; the state is IDLE on that same cycle.
- Back-to-back throughput: IDLE→SEND costs 2 cycles of overhead per command.
- If `resp_rdy` and timeout expiry coincide, the response wins.

## Configuration
- CMDQ_RETRY_EN defined:
  - On failure, while the retry count < MAX_RETRY, return to SEND with the same `cmd`, increment the retry count, and do not pulse `err`.
  - `err` pulses and `err_cnt` increments only after the final failed attempt.
  - The retry count clears on every pop.
- CMDQ_RETRY_EN undefined: no retry logic; the first failure abandons the command.

## Test plan
- After reset: push 16'h2002, 16'h4001, 16'h6000 with `en`=1 and a model ACKing 8'hA5 → three `send_cmd` pulses in order, three `done` pulses, `err_cnt`=0, `empty`=1.
- Fill: push 9 entries with `en`=0 → `full`=1, `count`=8, 9th dropped. Set `en`=1 → exactly 8 commands sent in push order, confirming pointer wrap.
- Model answers 8'h5A to the first command → `err` pulse, `last_resp`=8'h5A, `err_cnt`=1, next command still sent.
- No response, TIMEOUT=100 → `err` exactly 100 cycles after `send_cmd`. With CMDQ_RETRY_EN and MAX_RETRY=2 → 3 `send_cmd` pulses, then a single `err`.
- `resp_rdy` on the cycle the timeout expires → `done`, no `err`.
- Assert `rst_n` low during WAIT_RESP with 3 commands queued → all outputs 0, `empty`=1, no `send_cmd` after release until new pushes.
